// File: rtl/fetch_unit_if.sv
// Bundle of the fetch stage's two handshakes: instruction-memory request/response
// and the decode-side output.
interface fetch_unit_if #(
    parameter int ADDR_W  = 32,
    parameter int INSTR_W = 32
);
    logic               imem_req_valid;
    logic               imem_req_ready;
    logic [ADDR_W-1:0]  imem_req_addr;
    logic               imem_resp_valid;
    logic [INSTR_W-1:0] imem_resp_data;
    logic               if_valid;
    logic               if_ready;
    logic [INSTR_W-1:0] if_instr;
    logic [ADDR_W-1:0]  if_pc;

    // master = fetch unit, slave = memory plus decode
    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready, imem_resp_valid, imem_resp_data,
        output if_valid, if_instr, if_pc,
        input  if_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready, imem_resp_valid, imem_resp_data,
        input  if_valid, if_instr, if_pc,
        output if_ready
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: credit-limited prefetch queue in front of a variable-latency
// in-order instruction memory, predict-not-taken with redirect flush and wrong-path discard.
module fetch_unit #(
    parameter int               ADDR_W   = 32,
    parameter int               INSTR_W  = 32,
    parameter int               FQ_DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int               CNT_W    = $clog2(FQ_DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              halt,
    fetch_unit_if.master      bus,
    output logic [ADDR_W-1:0] fetch_pc
);
    localparam int PTR_W = $clog2(FQ_DEPTH);
    localparam logic [CNT_W:0] DEPTH_C = (CNT_W+1)'(FQ_DEPTH);

    logic [CNT_W-1:0]   count_reg, count_next;
    logic [CNT_W-1:0]   outstanding_reg, outstanding_next;
    logic [CNT_W-1:0]   discard_reg, discard_next;
    logic [ADDR_W-1:0]  fetch_pc_reg, resp_pc_reg;
    logic [PTR_W-1:0]   rd_ptr_reg, wr_ptr_reg;
    logic [INSTR_W-1:0] instr_arr [FQ_DEPTH];
    logic [ADDR_W-1:0]  pc_arr    [FQ_DEPTH];

    logic [CNT_W:0]     credit_used;
    logic               req_valid, req_fire, resp_fire, push, pop, empty;
    logic [ADDR_W-1:0]  target_pc;

    assign empty       = (count_reg == '0);
    assign credit_used = {1'b0, count_reg} + {1'b0, outstanding_reg};
    // Credits count both queued and in-flight entries, so a response always finds a slot.
    assign req_valid   = reset && !halt && !redirect_valid && (credit_used < DEPTH_C);
    assign req_fire    = req_valid && bus.imem_req_ready;
    assign resp_fire   = bus.imem_resp_valid;
    assign push        = resp_fire && !redirect_valid && (discard_reg == '0);
    assign pop         = !empty && bus.if_ready && !redirect_valid;
    assign target_pc   = redirect_pc & ~ADDR_W'(3);

    always_comb begin
        outstanding_next = outstanding_reg + CNT_W'(req_fire) - CNT_W'(resp_fire);
        discard_next     = discard_reg;
        if (redirect_valid)
            discard_next = outstanding_reg - CNT_W'(resp_fire);
        else if (resp_fire && discard_reg != '0)
            discard_next = discard_reg - CNT_W'(1);
        count_next = count_reg + CNT_W'(push) - CNT_W'(pop);
        if (redirect_valid)
            count_next = '0;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            count_reg       <= '0;
            outstanding_reg <= '0;
            discard_reg     <= '0;
            fetch_pc_reg    <= RESET_PC;
            resp_pc_reg     <= RESET_PC;
            rd_ptr_reg      <= '0;
            wr_ptr_reg      <= '0;
        end else begin
            count_reg       <= count_next;
            outstanding_reg <= outstanding_next;
            discard_reg     <= discard_next;
            if (redirect_valid) begin
                fetch_pc_reg <= target_pc;
                resp_pc_reg  <= target_pc;
                rd_ptr_reg   <= '0;
                wr_ptr_reg   <= '0;
            end else begin
                if (req_fire)
                    fetch_pc_reg <= fetch_pc_reg + ADDR_W'(4);
                if (push) begin
                    resp_pc_reg <= resp_pc_reg + ADDR_W'(4);
                    wr_ptr_reg  <= wr_ptr_reg + PTR_W'(1);
                end
                if (pop)
                    rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
        end
    end

    // Queue payload is data-only storage and needs no reset; the head is masked while empty.
    genvar gi;
    generate
        for (gi = 0; gi < FQ_DEPTH; gi++) begin : g_slot
            logic [INSTR_W-1:0] instr_reg;
            logic [ADDR_W-1:0]  pc_reg;
            always_ff @(posedge clk) begin
                if (push && wr_ptr_reg == PTR_W'(gi)) begin
                    instr_reg <= bus.imem_resp_data;
                    pc_reg    <= resp_pc_reg;
                end
            end
            assign instr_arr[gi] = instr_reg;
            assign pc_arr[gi]    = pc_reg;
        end
    endgenerate

    assign bus.imem_req_valid = req_valid;
    assign bus.imem_req_addr  = fetch_pc_reg;
    assign bus.if_valid       = !empty;
    assign bus.if_instr       = empty ? '0 : instr_arr[rd_ptr_reg];
    assign bus.if_pc          = empty ? '0 : pc_arr[rd_ptr_reg];
    assign fetch_pc           = fetch_pc_reg;
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: latency-programmable in-order memory model, epoch-tagged
// scoreboard of expected decode deliveries, directed scenarios plus a random phase.
module tb_fetch_unit;
    localparam int          AW    = 32;
    localparam int          IW    = 32;
    localparam int          DEPTH = 4;
    localparam logic [31:0] RPC   = 32'h0;

    logic        clk = 1'b0;
    logic        reset, redirect_valid, halt;
    logic [31:0] redirect_pc, fetch_pc;

    fetch_unit_if #(.ADDR_W(AW), .INSTR_W(IW)) bus ();

    fetch_unit #(
        .ADDR_W(AW), .INSTR_W(IW), .FQ_DEPTH(DEPTH), .RESET_PC(RPC)
    ) dut (
        .clk(clk), .reset(reset), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .halt(halt), .bus(bus), .fetch_pc(fetch_pc)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] addr; int epoch; int due; } mreq_t;
    typedef struct { logic [31:0] pc; logic [31:0] instr; } sb_t;

    mreq_t       mem_q[$];
    sb_t         sb[$];
    logic [31:0] popped_pc[$];
    logic [31:0] popped_instr[$];

    int checks = 0, errors = 0;
    int cyc = 0, epoch = 0, lat = 1;
    int n_pops = 0, n_fires = 0;
    bit rnd_ready = 0, checking = 0;
    logic [31:0] exp_fetch_pc = RPC;
    logic [31:0] last_fire_addr = '0;
    bit s_rst, s_req, s_resp, s_redir, s_pop;
    logic [31:0] s_addr, s_rpc;

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Sampled on the falling edge: checks against the model, then latches the handshakes.
    task automatic sample();
        bit exp_req;
        exp_req = reset && !halt && !redirect_valid && (sb.size() + mem_q.size() < DEPTH);
        if (checking) begin
            check_val("req_valid", bus.imem_req_valid, exp_req);
            check_val("fetch_pc", fetch_pc, exp_fetch_pc);
            if (bus.imem_req_valid) check_val("req_addr", bus.imem_req_addr, exp_fetch_pc);
            check_val("if_valid", bus.if_valid, sb.size() != 0);
            if (bus.if_valid && sb.size() != 0) begin
                check_val("if_pc", bus.if_pc, sb[0].pc);
                check_val("if_instr", bus.if_instr, sb[0].instr);
            end
            check_val("count_model", dut.count_reg, sb.size());
            check_val("outstanding_model", dut.outstanding_reg, mem_q.size());
            check_val("inv_count", dut.count_reg <= DEPTH, 1);
            check_val("inv_outstanding", dut.outstanding_reg <= DEPTH, 1);
            check_val("inv_discard", dut.discard_reg <= dut.outstanding_reg, 1);
        end
        s_rst   = !reset;
        s_req   = bus.imem_req_valid && bus.imem_req_ready;
        s_addr  = bus.imem_req_addr;
        s_resp  = bus.imem_resp_valid;
        s_redir = redirect_valid;
        s_rpc   = redirect_pc;
        s_pop   = reset && bus.if_valid && bus.if_ready && !redirect_valid;
        if (s_pop) begin
            n_pops++;
            popped_pc.push_back(bus.if_pc);
            popped_instr.push_back(bus.if_instr);
            $display("pop pc=%08h instr=%08h", bus.if_pc, bus.if_instr);
        end
        if (s_req && reset) begin
            n_fires++;
            last_fire_addr = s_addr;
        end
    endtask

    task automatic post_edge();
        mreq_t m;
        cyc++;
        if (s_rst) begin
            sb.delete();
            mem_q.delete();
            epoch++;
            exp_fetch_pc = RPC;
        end else begin
            if (s_pop && sb.size() != 0) void'(sb.pop_front());
            if (s_resp && mem_q.size() != 0) begin
                m = mem_q.pop_front();
                if (!s_redir && m.epoch == epoch)
                    sb.push_back('{m.addr, m.addr | 32'hA000_0000});
            end
            if (s_req) begin
                mem_q.push_back('{s_addr, epoch, cyc - 1 + lat});
                exp_fetch_pc = exp_fetch_pc + 32'd4;
            end
            if (s_redir) begin
                sb.delete();
                epoch++;
                exp_fetch_pc = s_rpc & ~32'h3;
            end
        end
        bus.imem_resp_valid = (mem_q.size() != 0) && (mem_q[0].due <= cyc);
        bus.imem_resp_data  = bus.imem_resp_valid ? (mem_q[0].addr | 32'hA000_0000) : 32'h0;
        bus.imem_req_ready  = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    endtask

    task automatic step();
        @(negedge clk);
        sample();
        @(posedge clk);
        #1;
        post_edge();
    endtask

    task automatic do_reset();
        reset = 1'b0;
        repeat (2) step();
        check_val("rst_if_valid", bus.if_valid, 0);
        check_val("rst_req_valid", bus.imem_req_valid, 0);
        check_val("rst_if_pc", bus.if_pc, 0);
        check_val("rst_if_instr", bus.if_instr, 0);
        check_val("rst_fetch_pc", fetch_pc, RPC);
    endtask

    initial begin
        int p0, f0, d_exp;
        reset = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; halt = 1'b0;
        bus.if_ready = 1'b1; bus.imem_req_ready = 1'b1;
        bus.imem_resp_valid = 1'b0; bus.imem_resp_data = '0;
        @(posedge clk);
        #1;
        checking = 1;

        // 1: zero-wait memory, 2-cycle first latency, then one instruction per cycle
        do_reset();
        reset = 1'b1;
        step();
        check_val("t1_c1_if_valid", bus.if_valid, 0);
        step();
        check_val("t1_c2_if_valid", bus.if_valid, 1);
        check_val("t1_c2_if_pc", bus.if_pc, 32'h0);
        check_val("t1_c2_if_instr", bus.if_instr, 32'hA000_0000);
        p0 = n_pops;
        repeat (20) step();
        check_val("t1_throughput", n_pops - p0, 20);

        // 2: decode stall fills exactly DEPTH credits, release drains without gaps
        do_reset();
        bus.if_ready = 1'b0;
        reset = 1'b1;
        f0 = n_fires;
        repeat (10) step();
        check_val("t2_fires", n_fires - f0, DEPTH);
        check_val("t2_req_idle", bus.imem_req_valid, 0);
        popped_pc.delete(); popped_instr.delete();
        bus.if_ready = 1'b1;
        repeat (5) step();
        check_val("t2_pops", popped_pc.size(), 5);
        for (int i = 0; i < 5 && i < popped_pc.size(); i++)
            check_val("t2_seq", popped_pc[i], 32'(4 * i));

        // 3: redirect with 3 in flight on a 3-cycle memory
        do_reset();
        lat = 3;
        reset = 1'b1;
        for (int i = 0; i < 30 && mem_q.size() != 3; i++) step();
        check_val("t3_three_inflight", mem_q.size(), 3);
        d_exp = mem_q.size() - int'(bus.imem_resp_valid);
        popped_pc.delete(); popped_instr.delete();
        redirect_valid = 1'b1; redirect_pc = 32'h103;
        step();
        redirect_valid = 1'b0;
        check_val("t3_discard", dut.discard_reg, d_exp);
        check_val("t3_if_valid", bus.if_valid, 0);
        for (int i = 0; i < 40 && popped_pc.size() == 0; i++) step();
        check_val("t3_first_seen", popped_pc.size() != 0, 1);
        if (popped_pc.size() != 0) begin
            check_val("t3_first_pc", popped_pc[0], 32'h100);
            check_val("t3_first_instr", popped_instr[0], 32'hA000_0100);
        end

        // 4: redirect colliding with a response and a decode pop
        do_reset();
        lat = 1;
        reset = 1'b1;
        for (int i = 0; i < 20 && !(bus.imem_resp_valid && bus.if_valid); i++) step();
        check_val("t4_setup", bus.imem_resp_valid && bus.if_valid, 1);
        d_exp = mem_q.size() - 1;
        popped_pc.delete(); popped_instr.delete();
        redirect_valid = 1'b1; redirect_pc = 32'h40;
        step();
        redirect_valid = 1'b0;
        check_val("t4_if_valid", bus.if_valid, 0);
        check_val("t4_count", dut.count_reg, 0);
        check_val("t4_discard", dut.discard_reg, d_exp);
        for (int i = 0; i < 20 && popped_pc.size() == 0; i++) step();
        check_val("t4_first_pc", popped_pc.size() != 0 ? popped_pc[0] : 32'hFFFF_FFFF, 32'h40);

        // 5: halt with 0x20/0x24 in flight, resume at 0x28
        do_reset();
        lat = 2;
        reset = 1'b1;
        for (int i = 0; i < 40 && exp_fetch_pc != 32'h28; i++) step();
        check_val("t5_setup_pc", exp_fetch_pc, 32'h28);
        popped_pc.delete(); popped_instr.delete();
        halt = 1'b1;
        f0 = n_fires;
        repeat (10) step();
        check_val("t5_no_fires", n_fires - f0, 0);
        check_val("t5_req_idle", bus.imem_req_valid, 0);
        check_val("t5_drained", popped_pc.size() != 0 ? popped_pc[$] : 32'hFFFF_FFFF, 32'h24);
        halt = 1'b0;
        step();
        check_val("t5_resume_fires", n_fires - f0, 1);
        check_val("t5_resume_addr", last_fire_addr, 32'h28);

        // 6: reset with a full queue
        do_reset();
        lat = 1;
        bus.if_ready = 1'b0;
        reset = 1'b1;
        for (int i = 0; i < 20 && sb.size() != DEPTH; i++) step();
        check_val("t6_full", dut.count_reg, DEPTH);
        reset = 1'b0;
        step();
        check_val("t6_if_valid", bus.if_valid, 0);
        check_val("t6_req_valid", bus.imem_req_valid, 0);
        step();
        reset = 1'b1;
        f0 = n_fires;
        step();
        check_val("t6_refetch_fires", n_fires - f0, 1);
        check_val("t6_refetch_addr", last_fire_addr, RPC);
        bus.if_ready = 1'b1;

        // Random mix of stalls, backpressure, halts and redirects
        rnd_ready = 1;
        lat = 2;
        for (int i = 0; i < 400; i++) begin
            bus.if_ready   = ($urandom_range(0, 3) != 0);
            halt           = ($urandom_range(0, 15) == 0);
            redirect_valid = ($urandom_range(0, 19) == 0);
            redirect_pc    = $urandom & 32'hFFF;
            step();
        end
        halt = 1'b0; redirect_valid = 1'b0; bus.if_ready = 1'b1;
        repeat (10) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
